// File: rtl/multi_fx.sv
// Signed fixed-point multiplier for the picoMIPS MULTI instruction: register * Q1.(IMM_W-1) immediate, one registered stage.
// Optional macro MULTI_SAT_EN clamps the result on overflow instead of wrapping.
module multi_fx #(
    parameter int REG_W  = 8,
    parameter int IMM_W  = 4,
    parameter int FRAC_W = 3
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             in_valid,
    input  logic [REG_W-1:0] register,
    input  logic [IMM_W-1:0] immediate,
    output logic             out_valid,
    output logic [REG_W-1:0] result,
    output logic             overflow
);
    localparam int P_W = REG_W + IMM_W;

    typedef struct packed {
        logic [REG_W-1:0] value;
        logic             ovf;
    } rsp_t;

    if (FRAC_W != IMM_W - 1) begin : g_cfg_err
        $error("multi_fx: FRAC_W must equal IMM_W-1");
    end

    logic signed [P_W-1:0]   prod;
    logic signed [P_W-1:0]   scaled;
    logic        [IMM_W:0]   hi_bits;
    logic                    ovf;
    rsp_t                    rsp_d;
    rsp_t                    rsp_q;
    logic                    vld_q;

    // Full-width product cannot lose bits; the shift floors toward -inf.
    assign prod    = $signed(register) * $signed(immediate);
    assign scaled  = prod >>> FRAC_W;
    // Fits in REG_W signed only if every bit above the result's MSB is a sign copy.
    assign hi_bits = scaled[P_W-1:REG_W-1];
    assign ovf     = !((&hi_bits) || !(|hi_bits));

    always_comb begin
        rsp_d.ovf   = ovf;
        rsp_d.value = scaled[REG_W-1:0];
`ifdef MULTI_SAT_EN
        if (ovf) begin
            rsp_d.value = scaled[P_W-1] ? {1'b1, {(REG_W-1){1'b0}}}
                                        : {1'b0, {(REG_W-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            vld_q <= 1'b0;
            rsp_q <= '0;
        end else begin
            vld_q <= in_valid;
            if (in_valid) rsp_q <= rsp_d;
        end
    end

    assign out_valid = vld_q;
    assign result    = rsp_q.value;
    assign overflow  = rsp_q.ovf;
endmodule

// File: tb/tb_multi_fx.sv
// Self-checking bench for multi_fx: directed spec cases, hold, async reset, and random traffic
// against an integer floor-division reference model.
module tb_multi_fx;
    logic       clk = 1'b0;
    logic       n_reset;
    logic       in_valid;
    logic [7:0] register;
    logic [3:0] immediate;
    logic       out_valid;
    logic [7:0] result;
    logic       overflow;

    int n_cmp = 0;
    int n_err = 0;

    // reference state: what the outputs should show after the next active edge
    logic       exp_vld;
    logic [7:0] exp_res;
    logic       exp_ovf;

    always #5 clk = ~clk;

    multi_fx dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .in_valid  (in_valid),
        .register  (register),
        .immediate (immediate),
        .out_valid (out_valid),
        .result    (result),
        .overflow  (overflow)
    );

    // value = register * (immediate / 8), floored to an integer
    function automatic void model(input logic [7:0] r, input logic [3:0] i,
                                  output logic [7:0] res, output logic ovf);
        int rv, iv, p, s;
        rv = $signed(r);
        iv = $signed(i);
        p  = rv * iv;
        if (p >= 0) s = p / 8;
        else        s = -((-p + 7) / 8);
        ovf = (s > 127) || (s < -128);
`ifdef MULTI_SAT_EN
        if (s > 127)       s = 127;
        else if (s < -128) s = -128;
`endif
        res = s[7:0];
    endfunction

    // drive one cycle's inputs (caller is at a falling edge) and advance the model
    task automatic issue(input logic v, input logic [7:0] r, input logic [3:0] i);
        in_valid  = v;
        register  = r;
        immediate = i;
        exp_vld   = v;
        if (v) model(r, i, exp_res, exp_ovf);
    endtask

    task automatic test_reset();
        n_reset = 1'b0;
        issue(1'b0, 8'd0, 4'd0);
        exp_res = 8'd0;
        exp_ovf = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b want 0", out_valid); end
        n_cmp++; if (result !== 8'd0) begin n_err++; $display("FAIL reset_result got %0d want 0", result); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %0b want 0", overflow); end
        n_reset = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL release_valid got %0b want 0", out_valid); end
    endtask

    task automatic test_directed();
        logic [7:0] r_t [5];
        logic [3:0] i_t [5];
        logic [7:0] e_t [5];
        logic       o_t [5];
        r_t[0] = 8'd6;    i_t[0] = 4'b0110; e_t[0] = 8'd4;    o_t[0] = 1'b0;
        r_t[1] = -8'sd6;  i_t[1] = 4'b0110; e_t[1] = -8'sd5;  o_t[1] = 1'b0;
        r_t[2] = 8'd127;  i_t[2] = 4'b0111; e_t[2] = 8'd111;  o_t[2] = 1'b0;
        r_t[3] = 8'h80;   i_t[3] = 4'b0111; e_t[3] = -8'sd112; o_t[3] = 1'b0;
        r_t[4] = 8'h80;   i_t[4] = 4'b1000; o_t[4] = 1'b1;
`ifdef MULTI_SAT_EN
        e_t[4] = 8'd127;
`else
        e_t[4] = 8'h80;
`endif
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            issue(1'b1, r_t[k], i_t[k]);
            @(negedge clk);
            issue(1'b0, 8'd0, 4'd0);
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL dir%0d_valid got %0b want 1", k, out_valid); end
            n_cmp++; if (result !== e_t[k]) begin n_err++; $display("FAIL dir%0d_result got %0d want %0d", k, $signed(result), $signed(e_t[k])); end
            n_cmp++; if (overflow !== o_t[k]) begin n_err++; $display("FAIL dir%0d_ovf got %0b want %0b", k, overflow, o_t[k]); end
        end
    endtask

    task automatic test_hold();
        @(negedge clk);
        issue(1'b1, 8'd6, 4'b0110);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            issue(1'b0, 8'($urandom), 4'($urandom));
            if (c > 0) begin
                n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL hold%0d_valid got %0b want 0", c, out_valid); end
            end
            n_cmp++; if (result !== 8'd4) begin n_err++; $display("FAIL hold%0d_result got %0d want 4", c, result); end
            n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL hold%0d_ovf got %0b want 0", c, overflow); end
        end
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL hold3_valid got %0b want 0", out_valid); end
        n_cmp++; if (result !== 8'd4) begin n_err++; $display("FAIL hold3_result got %0d want 4", result); end
    endtask

    task automatic run_traffic(input string tag, input int cycles, input bit always_valid);
        logic       v;
        logic [7:0] r;
        logic [3:0] i;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (c > 0) begin
                n_cmp++; if (out_valid !== exp_vld) begin n_err++; $display("FAIL %s%0d_valid got %0b want %0b", tag, c, out_valid, exp_vld); end
                n_cmp++; if (result !== exp_res) begin n_err++; $display("FAIL %s%0d_result got %0d want %0d", tag, c, $signed(result), $signed(exp_res)); end
                n_cmp++; if (overflow !== exp_ovf) begin n_err++; $display("FAIL %s%0d_ovf got %0b want %0b", tag, c, overflow, exp_ovf); end
            end
            v = always_valid ? 1'b1 : ($urandom_range(0, 3) != 0);
            r = 8'($urandom);
            i = 4'($urandom);
            if ($urandom_range(0, 9) == 0) begin r = 8'h80; i = 4'b1000; end
            if (c == cycles - 1) v = 1'b0;
            issue(v, r, i);
        end
    endtask

    task automatic test_random();
        run_traffic("rnd", 300, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_traffic("b2b", 60, 1'b1);
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        issue(1'b1, 8'd100, 4'b0101);
        @(posedge clk);
        #2;
        issue(1'b1, 8'h80, 4'b1000);
        n_reset = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL arst_valid got %0b want 0", out_valid); end
        n_cmp++; if (result !== 8'd0) begin n_err++; $display("FAIL arst_result got %0d want 0", result); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL arst_ovf got %0b want 0", overflow); end
        @(negedge clk);
        issue(1'b0, 8'd0, 4'd0);
        exp_res = 8'd0;
        exp_ovf = 1'b0;
        n_reset = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL arst_rel_valid got %0b want 0", out_valid); end
        n_cmp++; if (result !== 8'd0) begin n_err++; $display("FAIL arst_rel_result got %0d want 0", result); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_random();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
